// File: rtl/window_generator_3x3_pkg.sv
// Shared pixel-path definitions for the window generator, median filter and downstream stages.
// No logic and no latency.
// No flow control of its own.
package window_generator_3x3_pkg;

    localparam int PIX_W          = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/window_generator_3x3_line_buffer.sv
// One-row pixel store: a single address is read and written in the same cycle.
// Read data is combinational from the current address, so it shows the old value before the write lands.
// No backpressure; a write happens on every wr_en.
module window_generator_3x3_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are refilled by the first two rows of every frame, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[addr];

endmodule

// File: rtl/window_generator_3x3.sv
// Raster pixel stream to 3x3 neighbourhood; only full windows are emitted.
// Latency: one cycle from the accepted bottom-right pixel to oValid.
// No backpressure: every iValid pixel is accepted; iValid low freezes all state.
module window_generator_3x3
    import window_generator_3x3_pkg::*;
#(
    parameter int DATA_W     = PIX_W,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iValid,
    input  logic              iSof,
    input  logic [DATA_W-1:0] iPixel,
    output logic [DATA_W-1:0] oP11,
    output logic [DATA_W-1:0] oP12,
    output logic [DATA_W-1:0] oP13,
    output logic [DATA_W-1:0] oP21,
    output logic [DATA_W-1:0] oP22,
    output logic [DATA_W-1:0] oP23,
    output logic [DATA_W-1:0] oP31,
    output logic [DATA_W-1:0] oP32,
    output logic [DATA_W-1:0] oP33,
    output logic              oValid,
    output logic              oEof
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d, col_eff;
    logic [ROW_W-1:0] row_q, row_d, row_eff;

    // Index 0 is the leftmost column (c-2), index 2 the newest (c).
    logic [2:0][DATA_W-1:0] top_q, top_d;
    logic [2:0][DATA_W-1:0] mid_q, mid_d;
    logic [2:0][DATA_W-1:0] bot_q, bot_d;
    logic                   vld_q, vld_d;
    logic                   eof_q, eof_d;

    logic [DATA_W-1:0] lb1_rd_dat;
    logic [DATA_W-1:0] lb2_rd_dat;

    window_generator_3x3_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W)
    ) u_lb1 (
        .clk    (iClk),
        .wr_en  (iValid),
        .addr   (col_eff),
        .wr_dat (iPixel),
        .rd_dat (lb1_rd_dat)
    );

    // LB2 takes the row LB1 is giving up at this column.
    window_generator_3x3_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W)
    ) u_lb2 (
        .clk    (iClk),
        .wr_en  (iValid),
        .addr   (col_eff),
        .wr_dat (lb1_rd_dat),
        .rd_dat (lb2_rd_dat)
    );

    always_comb begin
        col_eff = (iValid && iSof) ? '0 : col_q;
        row_eff = (iValid && iSof) ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        top_d   = top_q;
        mid_d   = mid_q;
        bot_d   = bot_q;
        vld_d   = 1'b0;
        eof_d   = 1'b0;
        if (iValid) begin
            if (col_eff == COL_LAST) begin
                col_d = '0;
                row_d = (row_eff == ROW_LAST) ? '0 : row_eff + ROW_W'(1);
            end else begin
                col_d = col_eff + COL_W'(1);
                row_d = row_eff;
            end
            top_d = {lb2_rd_dat, top_q[2:1]};
            mid_d = {lb1_rd_dat, mid_q[2:1]};
            bot_d = {iPixel,     bot_q[2:1]};
            vld_d = (row_eff >= ROW_W'(2)) && (col_eff >= COL_W'(2));
            eof_d = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            col_q <= '0;
            row_q <= '0;
            top_q <= '0;
            mid_q <= '0;
            bot_q <= '0;
            vld_q <= 1'b0;
            eof_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            top_q <= top_d;
            mid_q <= mid_d;
            bot_q <= bot_d;
            vld_q <= vld_d;
            eof_q <= eof_d;
        end
    end

    assign oP11   = top_q[0];
    assign oP12   = top_q[1];
    assign oP13   = top_q[2];
    assign oP21   = mid_q[0];
    assign oP22   = mid_q[1];
    assign oP23   = mid_q[2];
    assign oP31   = bot_q[0];
    assign oP32   = bot_q[1];
    assign oP33   = bot_q[2];
    assign oValid = vld_q;
    assign oEof   = eof_q;

endmodule
